// File: rtl/con_dump_ctrl.sv
// con_dump_ctrl
//
// Post-run memory dump controller for the core's console port. While the
// program runs it counts cycles, tracks the highest data-memory word address
// stored to, and watches the fetched instruction. Once the instruction has
// stayed unchanged for IDLE_CYCLES cycles, or a manual dump request arrives,
// it sweeps data memory from word 0 up to that highest address. It streams
// each word to a downstream consumer over a valid/ready handshake.
//
// Ports:
//   CLK, nrst           clock, asynchronous active-low reset
//   inst                instruction currently in fetch
//   st_valid, st_addr   store in execute and its word address
//   dump_req            manual end-of-program request (honoured only in RUN)
//   con_addr, con_out   console read address / data (data one cycle later)
//   dout, dout_addr     dumped word and its address
//   dout_valid/ready    handshake; dout_last marks the final word
//   busy, done          scan in progress / dump complete (sticky)
//   run_cycles          program cycles excluding the idle-detect window
//   max_addr            highest stored word address seen during RUN
module con_dump_ctrl #(
    parameter int IDLE_CYCLES = 50,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic [31:0]       inst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic              dump_req,
    output logic [ADDR_W-1:0] con_addr,
    input  logic [DATA_W-1:0] con_out,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       run_cycles,
    output logic [ADDR_W-1:0] max_addr
);

    typedef enum logic [2:0] {
        S_RUN,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_FINISH
    } state_e;

    localparam logic [32:0] IDLE_LEN  = 33'(IDLE_CYCLES);
    localparam logic [31:0] IDLE_LAST = 32'(IDLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [31:0]       last_inst_q, last_inst_d;
    logic [31:0]       idle_cnt_q, idle_cnt_d;
    logic [31:0]       cyc_cnt_q, cyc_cnt_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic [ADDR_W-1:0] max_addr_q, max_addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] dout_addr_q, dout_addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_last_q, dout_last_d;

    logic              inst_same;
    logic              idle_hit;
    logic [32:0]       cyc_plus1;

    // Saturating subtraction: a run shorter than the subtracted window reads 0.
    function automatic logic [31:0] sat_sub(input logic [32:0] a, input logic [32:0] b);
        logic [32:0] diff;
        diff = a - b;
        if (a < b) begin
            return 32'd0;
        end
        return diff[31:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        last_inst_d  = last_inst_q;
        idle_cnt_d   = idle_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        run_cycles_d = run_cycles_q;
        max_addr_d   = max_addr_q;
        ptr_d        = ptr_q;
        dout_addr_d  = dout_addr_q;
        dout_d       = dout_q;
        dout_last_d  = dout_last_q;

        con_addr     = '0;
        dout_valid   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        inst_same    = (inst == last_inst_q);
        // idle_cnt counts repeats already seen; this cycle is repeat number
        // IDLE_CYCLES when the count has reached IDLE_CYCLES-1.
        idle_hit     = inst_same && (idle_cnt_q == IDLE_LAST);
        cyc_plus1    = {1'b0, cyc_cnt_q} + 33'd1;

        case (state_q)
            S_RUN: begin
                last_inst_d = inst;
                idle_cnt_d  = inst_same ? (idle_cnt_q + 32'd1) : 32'd0;
                cyc_cnt_d   = cyc_cnt_q + 32'd1;
                // A store in the exit cycle still counts.
                if (st_valid && (st_addr > max_addr_q)) begin
                    max_addr_d = st_addr;
                end
                if (idle_hit) begin
                    // The idle window itself is not program time.
                    run_cycles_d = sat_sub(cyc_plus1, IDLE_LEN);
                    ptr_d        = '0;
                    state_d      = S_ISSUE;
                end else if (dump_req) begin
                    run_cycles_d = cyc_plus1[31:0];
                    ptr_d        = '0;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                busy     = 1'b1;
                con_addr = ptr_q;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                // con_out now holds the word addressed during ISSUE.
                busy        = 1'b1;
                con_addr    = ptr_q;
                dout_d      = con_out;
                dout_addr_d = ptr_q;
                dout_last_d = (ptr_q == max_addr_q);
                state_d     = S_OUT;
            end

            S_OUT: begin
                busy       = 1'b1;
                con_addr   = ptr_q;
                dout_valid = 1'b1;
                if (dout_ready) begin
                    if (dout_last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_FINISH: begin
                done = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_RUN;
            last_inst_q  <= '0;
            idle_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
            run_cycles_q <= '0;
            max_addr_q   <= '0;
            ptr_q        <= '0;
            dout_addr_q  <= '0;
            dout_q       <= '0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_inst_q  <= last_inst_d;
            idle_cnt_q   <= idle_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            run_cycles_q <= run_cycles_d;
            max_addr_q   <= max_addr_d;
            ptr_q        <= ptr_d;
            dout_addr_q  <= dout_addr_d;
            dout_q       <= dout_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_last  = dout_last_q;
    assign run_cycles = run_cycles_q;
    assign max_addr   = max_addr_q;

endmodule

// File: tb/tb_con_dump_ctrl.sv
// Testbench for con_dump_ctrl: randomized program phases and handshake
// patterns, checked against a cycle-level behavioural model of the dump.
module tb_con_dump_ctrl;

    localparam int IDLE   = 5;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              nrst;
    logic [31:0]       inst;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic              dump_req;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_out;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_addr;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic [31:0]       run_cycles;
    logic [ADDR_W-1:0] max_addr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    con_dump_ctrl #(
        .IDLE_CYCLES(IDLE),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .inst      (inst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .dump_req  (dump_req),
        .con_addr  (con_addr),
        .con_out   (con_out),
        .dout      (dout),
        .dout_addr (dout_addr),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done),
        .run_cycles(run_cycles),
        .max_addr  (max_addr)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read data memory behind the console port.
    always @(posedge CLK) con_out <= mem[con_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check_eq({tag, "_dout"},       dout,            32'd0);
        check_eq({tag, "_dout_addr"},  32'(dout_addr),  32'd0);
        check_eq({tag, "_dout_last"},  32'(dout_last),  32'd0);
        check_eq({tag, "_busy"},       32'(busy),       32'd0);
        check_eq({tag, "_done"},       32'(done),       32'd0);
        check_eq({tag, "_con_addr"},   32'(con_addr),   32'd0);
        check_eq({tag, "_run_cycles"}, run_cycles,      32'd0);
        check_eq({tag, "_max_addr"},   32'(max_addr),   32'd0);
    endtask

    // One complete run. The program phase changes inst every cycle for
    // cycles 0..p-1. It then either holds inst (idle exit) or pulses dump_req
    // in cycle p-1. Either way the expected run_cycles is p. Stores land
    // in [0, amax] (amax < 0: none). exit_addr >= 0 forces a store in the
    // exit cycle. ready_mode: 0 always ready, 1 random, 2 seven-cycle stall
    // on address 1. rst_word >= 0 pulls reset during OUT of that word.
    task automatic run_case(input int p, input bit use_req, input bit zero_inst,
                            input int amax, input int exit_addr, input int ready_mode,
                            input int rst_word, input bit ramp_mem);
        int          x, cyc, exp_max, ea, next_out, limit, stall_left, fin_cyc;
        bit          fin, exp_v, rdy;
        logic [31:0] cur_inst, nx;

        for (int i = 0; i < (1 << ADDR_W); i++)
            mem[i] = ramp_mem ? 32'(i) * 32'h1111_1111 : $urandom;

        @(negedge CLK);
        nrst = 1'b0; inst = '0; st_valid = 1'b0; st_addr = '0;
        dump_req = 1'b0; dout_ready = 1'b0;
        @(negedge CLK);
        check_all_zero("reset");
        @(negedge CLK);
        nrst = 1'b1;

        x          = use_req ? p - 1 : p + IDLE - 1;
        exp_max    = 0;
        cur_inst   = '0;
        ea         = 0;
        next_out   = x + 3;
        fin        = 1'b0;
        fin_cyc    = 0;
        stall_left = 7;
        limit      = x + 20 * 64 + 100;

        for (cyc = 0; ; cyc++) begin
            // ---- observe the state of cycle cyc ----
            exp_v = 1'b0;
            if (cyc == x) begin
                check_eq("busy_last_run", 32'(busy), 32'd0);
                check_eq("valid_last_run", 32'(dout_valid), 32'd0);
                check_eq("con_addr_run", 32'(con_addr), 32'd0);
            end
            if (cyc > x) begin
                if (cyc == x + 1) begin
                    check_eq("run_cycles", run_cycles, 32'(p));
                    check_eq("max_addr", 32'(max_addr), 32'(exp_max));
                end
                exp_v = !fin && (cyc >= next_out);
                check_eq("busy", 32'(busy), 32'(!fin));
                check_eq("done", 32'(done), 32'(fin));
                check_eq("dout_valid", 32'(dout_valid), 32'(exp_v));
                if (!fin && (cyc == next_out - 2 || cyc == next_out - 1))
                    check_eq("con_addr_scan", 32'(con_addr), 32'(ea));
                if (fin)
                    check_eq("con_addr_fin", 32'(con_addr), 32'd0);
                if (exp_v) begin
                    check_eq("dout", dout, mem[ea]);
                    check_eq("dout_addr", 32'(dout_addr), 32'(ea));
                    check_eq("dout_last", 32'(dout_last), 32'(ea == exp_max));
                end
            end

            // ---- drive inputs for cycle cyc ----
            if (!zero_inst && cyc < p) begin
                nx = $urandom;
                if (nx == cur_inst) nx = nx ^ 32'd1;
                cur_inst = nx;
            end else if (cyc > x) begin
                cur_inst = $urandom;
            end
            inst     = cur_inst;
            dump_req = (use_req && cyc == p - 1) || (cyc > x && $urandom_range(0, 3) == 0);

            if (cyc < x) begin
                st_valid = (amax >= 0) && ($urandom_range(0, 2) == 0);
                st_addr  = (amax >= 0) ? ADDR_W'($urandom_range(0, amax)) : '0;
            end else if (cyc == x) begin
                st_valid = (exit_addr >= 0);
                st_addr  = (exit_addr >= 0) ? ADDR_W'(exit_addr) : '0;
            end else begin
                st_valid = 1'($urandom_range(0, 1));
                st_addr  = ADDR_W'($urandom);
            end
            if (cyc <= x && st_valid && int'(st_addr) > exp_max) exp_max = int'(st_addr);

            rdy = 1'b1;
            if (cyc <= x) rdy = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) rdy = ($urandom_range(0, 2) != 0);
            else if (ready_mode == 2 && exp_v && ea == 1 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            dout_ready = rdy;

            if (exp_v && ea == rst_word) begin
                nrst = 1'b0;
                #1;
                check_all_zero("mid_reset");
                return;
            end

            // ---- model update on handshake ----
            if (exp_v && rdy) begin
                if (ea == exp_max) begin
                    fin     = 1'b1;
                    fin_cyc = cyc + 1;
                end else begin
                    ea++;
                    next_out = cyc + 3;
                end
            end

            if (fin && cyc >= fin_cyc + 6) break;
            if (cyc > limit) begin
                check_eq("timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge CLK);
        end
        check_eq("final_max_addr", 32'(max_addr), 32'(exp_max));
        check_eq("final_run_cycles", run_cycles, 32'(p));
    endtask

    initial begin
        nrst = 1'b0; inst = '0; st_valid = 1'b0; st_addr = '0;
        dump_req = 1'b0; dout_ready = 1'b0;

        // ramp memory, stores up to 9, idle exit
        run_case(30, 1'b0, 1'b0, 9, 9, 0, -1, 1'b1);
        // no stores, inst 0 from reset: single word, run_cycles 0
        run_case(0, 1'b0, 1'b1, -1, -1, 0, -1, 1'b1);
        // manual request in cycle 20 -> run_cycles 21, addresses 0..2
        run_case(21, 1'b1, 1'b0, 2, 2, 0, -1, 1'b0);
        // seven-cycle stall on address 1
        run_case(12, 1'b0, 1'b0, 5, 5, 2, -1, 1'b0);
        // store to 12 in the exit cycle
        run_case(15, 1'b0, 1'b0, 8, 12, 0, -1, 1'b0);
        run_case(15, 1'b1, 1'b0, 8, 12, 1, -1, 1'b0);
        // reset during OUT of word 4, then a fresh full run
        run_case(10, 1'b0, 1'b0, 6, 9, 0, 4, 1'b1);
        run_case(10, 1'b0, 1'b0, 6, 9, 0, -1, 1'b1);
        // random mix
        for (int k = 0; k < 6; k++) begin
            run_case($urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'b0,
                     $urandom_range(0, 20),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1,
                     $urandom_range(0, 1), -1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/con_dump_ctrl.md
# con_dump_ctrl

Post-run memory dump controller that sits on the core's console port (`con_addr`/`con_out`) and drives it once the program has finished. It detects end of program when the fetched instruction stays constant for a configurable number of cycles, or on a manual request. It tracks the highest data-memory word address stored to, then sweeps data memory from address 0 to that address. Each word is streamed to a downstream consumer (UART transmitter or checker) over a valid/ready handshake, together with run-time cycle statistics.

## Interface
Parameters:
- `IDLE_CYCLES`, 50: consecutive unchanged-instruction cycles that declare end of program (≥2).
- `ADDR_W`, 10: data-memory word-address width.
- `DATA_W`, 32: data word width.

Ports:
- `CLK`  in  1  system clock; all state on rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `inst`  in  32  instruction currently in fetch (core `if_inst`).
- `st_valid`  in  1  store in execute with any byte-write enable set.
- `st_addr`  in  ADDR_W  word address of that store (ALU result bits [ADDR_W+1:2]).
- `dump_req`  in  1  manual end-of-program request; honoured only in RUN.
- `con_addr`  out  ADDR_W  read address to core console port.
- `con_out`  in  DATA_W  read data from console port, valid one cycle after `con_addr`.
- `dout`  out  DATA_W  dumped word.
- `dout_addr`  out  ADDR_W  address of `dout`.
- `dout_valid`  out  1  `dout`/`dout_addr`/`dout_last` valid.
- `dout_ready`  in  1  consumer accepts the word this cycle.
- `dout_last`  out  1  current word is the final one (address == max address).
- `busy`  out  1  scan in progress.
- `done`  out  1  dump complete; sticky until reset.
- `run_cycles`  out  32  program cycles, excluding the idle-detect window.
- `max_addr`  out  ADDR_W  highest stored word address seen.

## Operation
- States: RUN → ISSUE → WAIT → OUT → (ISSUE | FINISH). FINISH is terminal until reset.
- RUN:
  - `last_inst <= inst` every cycle.
  - `idle_cnt` increments when `inst == last_inst` and clears otherwise.
  - `cyc_cnt` increments every cycle, unsaturated, wraps at 2^32.
  - On `st_valid && st_addr > max_addr`, `max_addr <= st_addr`.
  - Leave RUN when `idle_cnt == IDLE_CYCLES-1` and `inst == last_inst`, or when `dump_req`. On exit:
    - `run_cycles <= cyc_cnt + 1 - IDLE_CYCLES` when idle-triggered, or `cyc_cnt + 1` when request-triggered. Saturate at 0.
    - `ptr <= 0`.
  - A store coinciding with the exit cycle still updates `max_addr`.
- ISSUE: `con_addr = ptr`.
- WAIT: `con_addr = ptr`; capture `con_out` into `dout`, `ptr` into `dout_addr`, and `(ptr == max_addr)` into `dout_last`.
- OUT:
  - `dout_valid = 1`; outputs are held stable until `dout_valid && dout_ready`.
  - On transfer: go to FINISH if `dout_last`, else `ptr <= ptr + 1` and go to ISSUE.
- FINISH: `done = 1`, `busy = 0`, `dout_valid = 0`, `con_addr = 0`. Further `st_valid`, `dump_req` and `inst` changes are ignored.
- `busy = 1` in ISSUE, WAIT and OUT.
- `con_addr = 0` in RUN and FINISH.
- `max_addr` and `st_*` are ignored outside RUN.
- Words dumped = `max_addr + 1`. If no store ever occurs, exactly one word (address 0) is dumped. `ptr` never wraps, because the sweep ends at `max_addr ≤ 2^ADDR_W - 1`.

## Timing
- Reset values (asynchronous, immediate):
  - state RUN.
  - Outputs `con_addr`, `dout`, `dout_addr`, `dout_valid`, `dout_last`, `busy`, `done`, `run_cycles`, `max_addr` all 0.
  - Internal `last_inst`, `idle_cnt`, `cyc_cnt`, `ptr` all 0.
  - Reset mid-scan drops `dout_valid` in the same instant, with no partial handshake.
- `last_inst` resets to 0, so a constant `inst = 0` from reset counts as idle.
- Idle detection: with `inst` constant from cycle k, RUN exits on the edge ending cycle k + IDLE_CYCLES - 1 (relative to the first repeated cycle).
- `dump_req` sampled high in RUN: ISSUE is entered on the next edge.
- Per word with `dout_ready` held high: 3 cycles (ISSUE, WAIT, OUT).
- `dout_valid` first rises 2 cycles after leaving RUN.
- `dout_ready` low in OUT stalls indefinitely; data stays unchanged.
- `done` rises on the edge of the final handshake.

## Test plan
- Stores to word addresses 3, 9, 5, then a looping `jal x0,0` (`0000006F`) held; data memory preloaded with `mem[i] = i*0x11111111`, `dout_ready = 1`:
  - dump of addresses 0..9 with the matching values; `dout_last` only at address 9; `max_addr = 9`.
  - `done` rises exactly 30 cycles after the first `dout_valid` cycle minus 2.
- No stores, `IDLE_CYCLES = 4`, `inst` constant 0 from reset → exit after 3 cycles. `run_cycles = 0`; single word at address 0 with `dout_last = 1`.
- `dump_req` pulse at cycle 20, `inst` changing every cycle, last store to 2 → `run_cycles = 21`; addresses 0..2 dumped.
- `dout_ready` low for 7 cycles on the word at address 1 → `dout`/`dout_addr` stable for all 7 cycles; no word skipped or duplicated.
- Store to address 12 in the exact exit cycle → `max_addr = 12`; 13 words dumped.
- `nrst` low during OUT of word 4 → all outputs 0 immediately. After release, a fresh run repeats the full dump from address 0.
